id_scoreboard: RTL and testbench

Parametrised register-hazard scoreboard for the decode stage. It tracks the destination register of every in-flight instruction in the NSTAGE stages after ID (EX, MEM, WB for the default), each tagged with the stage at which its result becomes forwardable. From this it produces the ID stall request and per-source forwarding selects. It generalises the fixed EX-only load/CSR interlock to arbitrary depth and per-instruction result latency, and adds a stall-cycle performance counter.

---
 rtl/id_scoreboard.sv | 151 +++++++++++++++
 tb/tb_id_scoreboard.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// id_scoreboard: decode-stage register-hazard scoreboard with stall request, forwarding selects and stall counter.
// Build option: define SB_FWD_EN for forwarding; without it the block is a pure interlock and fwd_sel* stay 0.
module id_scoreboard #(
  parameter int NSTAGE = 3,
  parameter int AW     = 5,
  parameter int FSEL_W = $clog2(NSTAGE + 1),
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [NSTAGE+1:0]   stall,
  input  logic                issue_we,
  input  logic [AW-1:0]       issue_waddr,
  input  logic [FSEL_W-1:0]   issue_rdy,
  input  logic [AW-1:0]       rs1,
  input  logic [AW-1:0]       rs2,
  input  logic                rs1_en,
  input  logic                rs2_en,
  output logic                stallreq_id,
  output logic [FSEL_W-1:0]   fwd_sel1,
  output logic [FSEL_W-1:0]   fwd_sel2,
  output logic [CNT_W-1:0]    stall_cnt
);

  logic [NSTAGE-1:0] valid_q, valid_d;
  logic [NSTAGE-1:0] we_q, we_d;
  logic [AW-1:0]     waddr_q [NSTAGE];
  logic [AW-1:0]     waddr_d [NSTAGE];
  logic [FSEL_W-1:0] rdy_q   [NSTAGE];
  logic [FSEL_W-1:0] rdy_d   [NSTAGE];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [AW-1:0]     src_s [2];
  logic [1:0]        en_s;
  logic [1:0]        haz_s;
  logic              unused_stall_s;

  assign src_s[0]       = rs1;
  assign src_s[1]       = rs2;
  assign en_s           = {rs2_en, rs1_en};
  // stall[0] belongs to IF, which has no entry here.
  assign unused_stall_s = stall[0];

`ifdef SB_FWD_EN
  logic [FSEL_W-1:0] sel_s [2];

  // Youngest matching entry decides: scan oldest to youngest so the lowest index wins.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      haz_s[k] = 1'b0;
      sel_s[k] = '0;
      for (int p = NSTAGE - 1; p >= 0; p--) begin
        if (valid_q[p] && we_q[p] && (waddr_q[p] == src_s[k]) &&
            (src_s[k] != '0) && en_s[k]) begin
          haz_s[k] = (rdy_q[p] > FSEL_W'(p));
          sel_s[k] = FSEL_W'(p + 1);
        end else begin
          haz_s[k] = haz_s[k];
        end
      end
    end
  end

  assign fwd_sel1 = sel_s[0];
  assign fwd_sel2 = sel_s[1];
`else
  // Interlock only: any match whose result is not yet in the register file stalls.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      haz_s[k] = 1'b0;
      for (int p = 0; p < NSTAGE; p++) begin
        if (valid_q[p] && we_q[p] && (waddr_q[p] == src_s[k]) &&
            (src_s[k] != '0) && en_s[k]) begin
          haz_s[k] = haz_s[k] | (rdy_q[p] != FSEL_W'(NSTAGE));
        end else begin
          haz_s[k] = haz_s[k];
        end
      end
    end
  end

  assign fwd_sel1 = '0;
  assign fwd_sel2 = '0;
`endif

  assign stallreq_id = |haz_s;
  assign stall_cnt   = cnt_q;

  // Entry advance: flush, then hold on own-stage stall, then bubble when only the stage above is stalled.
  always_comb begin
    for (int p = 0; p < NSTAGE; p++) begin
      valid_d[p] = valid_q[p];
      we_d[p]    = we_q[p];
      waddr_d[p] = waddr_q[p];
      rdy_d[p]   = rdy_q[p];
      if (flush) begin
        valid_d[p] = 1'b0;
        we_d[p]    = 1'b0;
        waddr_d[p] = '0;
        rdy_d[p]   = '0;
      end else if (stall[p+2]) begin
        valid_d[p] = valid_q[p];
      end else if (stall[p+1]) begin
        valid_d[p] = 1'b0;
        we_d[p]    = 1'b0;
      end else if (p == 0) begin
        valid_d[p] = 1'b1;
        we_d[p]    = issue_we;
        waddr_d[p] = issue_waddr;
        rdy_d[p]   = issue_rdy;
      end else begin
        valid_d[p] = valid_q[p-1];
        we_d[p]    = we_q[p-1];
        waddr_d[p] = waddr_q[p-1];
        rdy_d[p]   = rdy_q[p-1];
      end
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    if (stallreq_id && !flush && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      we_q    <= '0;
      cnt_q   <= '0;
      for (int p = 0; p < NSTAGE; p++) begin
        waddr_q[p] <= '0;
        rdy_q[p]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      for (int p = 0; p < NSTAGE; p++) begin
        waddr_q[p] <= waddr_d[p];
        rdy_q[p]   <= rdy_d[p];
      end
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: directed scenarios plus random traffic against a behavioural model.
module tb_id_scoreboard;
  localparam int NSTAGE = 3;
  localparam int AW     = 5;
  localparam int FSEL_W = $clog2(NSTAGE + 1);
  localparam int CNT_W  = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [NSTAGE+1:0] stall;
  logic              issue_we;
  logic [AW-1:0]     issue_waddr;
  logic [FSEL_W-1:0] issue_rdy;
  logic [AW-1:0]     rs1, rs2;
  logic              rs1_en, rs2_en;
  logic              stallreq_id;
  logic [FSEL_W-1:0] fwd_sel1, fwd_sel2;
  logic [CNT_W-1:0]  stall_cnt;

  int    n_checks = 0;
  int    n_err    = 0;
  int    m_v   [NSTAGE];
  int    m_we  [NSTAGE];
  int    m_wa  [NSTAGE];
  int    m_rdy [NSTAGE];
  longint m_cnt;

  always #5 clk = ~clk;

  id_scoreboard #(.NSTAGE(NSTAGE), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .issue_we(issue_we), .issue_waddr(issue_waddr), .issue_rdy(issue_rdy),
    .rs1(rs1), .rs2(rs2), .rs1_en(rs1_en), .rs2_en(rs2_en),
    .stallreq_id(stallreq_id), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .stall_cnt(stall_cnt)
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int p = 0; p < NSTAGE; p++) begin
      m_v[p] = 0; m_we[p] = 0; m_wa[p] = 0; m_rdy[p] = 0;
    end
    m_cnt = 0;
  endfunction

  // Reference lookup: hazard and forward index for one source register.
  function automatic void ref_src(input int s, input int en, output int haz, output int sel);
    haz = 0;
    sel = 0;
    if (s == 0 || en == 0) return;
`ifdef SB_FWD_EN
    for (int p = 0; p < NSTAGE; p++) begin
      if (m_v[p] != 0 && m_we[p] != 0 && m_wa[p] == s) begin
        haz = (m_rdy[p] > p) ? 1 : 0;
        sel = p + 1;
        return;
      end
    end
`else
    for (int p = 0; p < NSTAGE; p++) begin
      if (m_v[p] != 0 && m_we[p] != 0 && m_wa[p] == s && m_rdy[p] < NSTAGE) haz = 1;
    end
`endif
  endfunction

  // Check outputs for the current inputs, then advance the model across one rising edge.
  task automatic cycle();
    int h1, s1, h2, s2, req;
    int nv[NSTAGE], nwe[NSTAGE], nwa[NSTAGE], nrdy[NSTAGE];
    #1;
    ref_src(int'(rs1), int'(rs1_en), h1, s1);
    ref_src(int'(rs2), int'(rs2_en), h2, s2);
    req = h1 | h2;
    check_eq("stallreq_id", longint'(stallreq_id), longint'(req));
`ifdef SB_FWD_EN
    if (req == 0) begin
      check_eq("fwd_sel1", longint'(fwd_sel1), longint'(s1));
      check_eq("fwd_sel2", longint'(fwd_sel2), longint'(s2));
    end
`else
    check_eq("fwd_sel1", longint'(fwd_sel1), 0);
    check_eq("fwd_sel2", longint'(fwd_sel2), 0);
`endif
    check_eq("stall_cnt", longint'(stall_cnt), m_cnt);
    @(posedge clk);
    for (int p = 0; p < NSTAGE; p++) begin
      nv[p] = m_v[p]; nwe[p] = m_we[p]; nwa[p] = m_wa[p]; nrdy[p] = m_rdy[p];
      if (flush) begin
        nv[p] = 0; nwe[p] = 0; nwa[p] = 0; nrdy[p] = 0;
      end else if (stall[p+2]) begin
        nv[p] = m_v[p];
      end else if (stall[p+1]) begin
        nv[p] = 0;
      end else if (p == 0) begin
        nv[p] = 1; nwe[p] = int'(issue_we); nwa[p] = int'(issue_waddr); nrdy[p] = int'(issue_rdy);
      end else begin
        nv[p] = m_v[p-1]; nwe[p] = m_we[p-1]; nwa[p] = m_wa[p-1]; nrdy[p] = m_rdy[p-1];
      end
    end
    for (int p = 0; p < NSTAGE; p++) begin
      m_v[p] = nv[p]; m_we[p] = nwe[p]; m_wa[p] = nwa[p]; m_rdy[p] = nrdy[p];
    end
    if (req != 0 && !flush && m_cnt < (64'd1 << CNT_W) - 1) m_cnt++;
    @(negedge clk);
  endtask

  task automatic issue(input int we, input int wa, input int rdy);
    issue_we    = 1'(we);
    issue_waddr = AW'(wa);
    issue_rdy   = FSEL_W'(rdy);
  endtask

  task automatic srcs(input int a, input int ae, input int b, input int be);
    rs1 = AW'(a); rs1_en = 1'(ae); rs2 = AW'(b); rs2_en = 1'(be);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_stallreq", longint'(stallreq_id), 0);
    check_eq("rst_cnt", longint'(stall_cnt), 0);
    check_eq("rst_fwd1", longint'(fwd_sel1), 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; stall = '0;
    issue(0, 0, 0);
    srcs(0, 0, 0, 0);
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_stallreq", longint'(stallreq_id), 0);
    check_eq("reset_fwd1", longint'(fwd_sel1), 0);
    check_eq("reset_fwd2", longint'(fwd_sel2), 0);
    check_eq("reset_cnt", longint'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU forward
    issue(1, 5, 0); cycle();
    issue(0, 0, 0); srcs(5, 1, 0, 0); cycle();
    // Load-use with the core turning the request into an ID stall
    issue(1, 6, 1); srcs(0, 0, 0, 0); cycle();
    issue(0, 0, 0); srcs(0, 0, 6, 1); stall = 5'b00010; cycle();
    stall = '0; cycle(); cycle();
    // Youngest wins
    issue(1, 7, 0); srcs(0, 0, 0, 0); cycle(); cycle();
    issue(0, 0, 0); srcs(7, 1, 7, 1); cycle();
    // x0 and disabled source
    issue(1, 0, 1); srcs(0, 0, 0, 0); cycle();
    issue(1, 9, 0); srcs(0, 1, 0, 0); cycle();
    issue(0, 0, 0); srcs(0, 0, 9, 0); cycle();
    // Flush over three valid entries with stalls asserted
    issue(1, 3, 2); cycle(); cycle(); cycle();
    flush = 1'b1; stall = '1; srcs(3, 1, 3, 1); cycle();
    flush = 1'b0; stall = '0; issue(0, 0, 0); cycle();
    // Held hazard, reset mid-stall, then saturation
    issue(1, 5, 2); srcs(0, 0, 0, 0); cycle();
    stall = '1; srcs(5, 1, 0, 0);
    repeat (5) cycle();
    async_reset();
    stall = '0; issue(1, 5, 2); srcs(0, 0, 0, 0); cycle();
    stall = '1; srcs(5, 1, 0, 0);
    repeat (70) cycle();
    stall = '0;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      flush = ($urandom_range(29) == 0);
      for (int b = 0; b < NSTAGE + 2; b++) stall[b] = ($urandom_range(5) == 0);
      issue(int'($urandom_range(1)), int'($urandom_range(3)), int'($urandom_range(NSTAGE)));
      srcs(int'($urandom_range(3)), int'($urandom_range(3) != 0),
           int'($urandom_range(3)), int'($urandom_range(3) != 0));
      if (i == 300) async_reset();
      else cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
